// File: rtl/sine_tone_sequencer.sv
// Tone sequencer feeding Scale/Enable of the sinewave generator.
// Plays a table of {scale, duration} entries with optional gap and loop.
module sine_tone_sequencer #(
  parameter int DEPTH     = 16,
  parameter int TICK_DIV  = 1024,
  parameter int GAP_TICKS = 1,
  localparam int IW = $clog2(DEPTH),
  localparam int PW = $clog2(TICK_DIV)
) (
  input  logic          sysclk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_addr,
  input  logic [5:0]    wr_scale,
  input  logic [7:0]    wr_dur,
  input  logic          start,
  input  logic          stop,
  input  logic          loop_en,
  input  logic [IW-1:0] last_idx,
  output logic [5:0]    Scale_Out,
  output logic          Enable_Out,
  output logic          busy,
  output logic          done,
  output logic [IW-1:0] cur_idx
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] PLAY = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;

  logic [1:0]    state;
  logic [PW-1:0] prescaler;
  logic [7:0]    dur_left;
  logic [15:0]   gap_left;
  logic [5:0]    tbl_scale [DEPTH];
  logic [7:0]    tbl_dur   [DEPTH];
  logic [5:0]    ld_scale;
  logic [7:0]    ld_dur;
  logic          tick;
  logic          adv;

  assign busy     = (state != IDLE);
  assign ld_scale = tbl_scale[cur_idx];
  assign ld_dur   = tbl_dur[cur_idx];
  assign tick     = (prescaler == PW'(TICK_DIV - 1));

  // Tone table: written any time, read only in LOAD.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_scale[i] <= '0;
        tbl_dur[i]   <= '0;
      end
    end else if (wr_en) begin
      tbl_scale[wr_addr] <= wr_scale;
      tbl_dur[wr_addr]   <= wr_dur;
    end
  end

  // End of an entry: skipped, played with no gap, or gap finished.
  always_comb begin
    adv = 1'b0;
    unique case (state)
      LOAD:    adv = (ld_dur == 8'd0);
      PLAY:    adv = tick && (dur_left == 8'd1)
                     && (GAP_TICKS == 0);
      GAP:     adv = tick && (gap_left == 16'd1);
      default: adv = 1'b0;
    endcase
  end

  // Playback FSM with registered generator outputs.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cur_idx    <= '0;
      prescaler  <= '0;
      dur_left   <= '0;
      gap_left   <= '0;
      Scale_Out  <= 6'd1;
      Enable_Out <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop && (state != IDLE)) begin
        state      <= IDLE;
        Enable_Out <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && !stop) begin
              state   <= LOAD;
              cur_idx <= '0;
            end
          end
          LOAD: begin
            dur_left  <= ld_dur;
            prescaler <= '0;
            if (ld_dur != 8'd0) begin
              state      <= PLAY;
              Enable_Out <= (ld_scale != 6'd0);
              if (ld_scale != 6'd0)
                Scale_Out <= ld_scale;
            end
          end
          PLAY: begin
            if (tick) begin
              prescaler <= '0;
              dur_left  <= dur_left - 8'd1;
              if ((dur_left == 8'd1) && (GAP_TICKS > 0)) begin
                state      <= GAP;
                gap_left   <= 16'(GAP_TICKS);
                Enable_Out <= 1'b0;
              end
            end else begin
              prescaler <= prescaler + PW'(1);
            end
          end
          GAP: begin
            if (tick) begin
              prescaler <= '0;
              gap_left  <= gap_left - 16'd1;
            end else begin
              prescaler <= prescaler + PW'(1);
            end
          end
          default: state <= IDLE;
        endcase
        if (adv) begin
          Enable_Out <= 1'b0;
          if (cur_idx != last_idx) begin
            cur_idx <= cur_idx + IW'(1);
            state   <= LOAD;
          end else if (loop_en) begin
            cur_idx <= '0;
            state   <= LOAD;
          end else begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sine_tone_sequencer.sv
// Self-checking bench for sine_tone_sequencer.
// Expected traces come from a per-entry playback model.
module tb_sine_tone_sequencer;

  localparam int DEPTH = 8;
  localparam int TD    = 4;
  localparam int GT    = 1;
  localparam int IW    = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic [IW-1:0] wr_addr = '0;
  logic [5:0]    wr_scale = '0;
  logic [7:0]    wr_dur = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loop_en = 1'b0;
  logic [IW-1:0] last_idx = '0;
  logic [5:0]    Scale_Out;
  logic          Enable_Out;
  logic          busy;
  logic          done;
  logic [IW-1:0] cur_idx;
  logic [11:0]   obs;

  int checks = 0;
  int errors = 0;
  int m_scale [DEPTH];
  int m_dur   [DEPTH];
  int mscale = 1;
  logic [11:0] exp_q [$];

  sine_tone_sequencer #(
    .DEPTH(DEPTH), .TICK_DIV(TD), .GAP_TICKS(GT)
  ) dut (
    .sysclk(clk), .reset(reset), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_scale(wr_scale),
    .wr_dur(wr_dur), .start(start), .stop(stop),
    .loop_en(loop_en), .last_idx(last_idx),
    .Scale_Out(Scale_Out), .Enable_Out(Enable_Out),
    .busy(busy), .done(done), .cur_idx(cur_idx)
  );

  always #5 clk = ~clk;

  assign obs = {Scale_Out, Enable_Out, busy, done, cur_idx};

  function automatic logic [11:0] pk(int s, bit e, bit b,
                                     bit d, int i);
    return {6'(s), e, b, d, 3'(i)};
  endfunction

  // Playback of entries first..last (wrapping), one item per cycle.
  task automatic mdl(input int first, input int last,
                     input bit fin);
    int idx;
    idx = first;
    forever begin
      exp_q.push_back(pk(mscale, 0, 1, 0, idx));
      if (m_dur[idx] != 0) begin
        if (m_scale[idx] != 0) mscale = m_scale[idx];
        repeat (m_dur[idx] * TD)
          exp_q.push_back(pk(mscale, m_scale[idx] != 0,
                             1, 0, idx));
        repeat (GT * TD)
          exp_q.push_back(pk(mscale, 0, 1, 0, idx));
      end
      if (idx == last) break;
      idx = (idx + 1) % DEPTH;
    end
    if (fin) exp_q.push_back(pk(mscale, 0, 0, 1, last));
  endtask

  task automatic wr(input int a, input int s, input int d);
    wr_en = 1'b1;
    wr_addr = 3'(a);
    wr_scale = 6'(s);
    wr_dur = 8'(d);
    m_scale[a] = s;
    m_dur[a] = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic kick();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    checks++;
    if (obs !== pk(1, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL reset_init got %h exp %h",
               obs, pk(1, 0, 0, 0, 0));
    end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    wr(0, 10, 2);
    last_idx = 0;
    kick();
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({Enable_Out, Scale_Out} !== {1'b1, 6'd10}) begin
      errors++;
      $display("FAIL pre_reset_play got %b/%0d exp 1/10",
               Enable_Out, Scale_Out);
    end
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== pk(1, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL reset_async got %h exp %h",
               obs, pk(1, 0, 0, 0, 0));
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      m_scale[i] = 0;
      m_dur[i] = 0;
    end
    mscale = 1;
    exp_q.delete();
    mdl(0, 0, 1);
    kick();
    foreach (exp_q[i]) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL reset_cleared cyc %0d got %h exp %h",
                 i, obs, exp_q[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_basic();
    wr(0, 10, 2);
    wr(1, 20, 1);
    last_idx = 1;
    exp_q.delete();
    mdl(0, 1, 1);
    kick();
    foreach (exp_q[i]) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL basic cyc %0d got %h exp %h",
                 i, obs, exp_q[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rest_skip();
    wr(0, 12, 1);
    wr(1, 0, 2);
    wr(2, 33, 0);
    wr(3, 7, 1);
    last_idx = 3;
    exp_q.delete();
    mdl(0, 3, 1);
    kick();
    foreach (exp_q[i]) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL rest_skip cyc %0d got %h exp %h",
                 i, obs, exp_q[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_loop_stop();
    wr(0, 5, 1);
    last_idx = 0;
    loop_en = 1'b1;
    exp_q.delete();
    repeat (3) mdl(0, 0, 0);
    kick();
    foreach (exp_q[i]) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL loop cyc %0d got %h exp %h",
                 i, obs, exp_q[i]);
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    loop_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== pk(5, 0, 0, 0, 0)) begin
        errors++;
        $display("FAIL stop cyc %0d got %h exp %h",
                 k, obs, pk(5, 0, 0, 0, 0));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_priority();
    start = 1'b1;
    stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stop = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_stop_idle busy got %b exp 0", busy);
    end
    @(posedge clk); #1;
    wr(0, 10, 1);
    last_idx = 0;
    exp_q.delete();
    mdl(0, 0, 1);
    kick();
    foreach (exp_q[i]) begin
      start = (i == 2);
      @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL start_ignored cyc %0d got %h exp %h",
                 i, obs, exp_q[i]);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_live_write();
    wr(0, 10, 1);
    last_idx = 0;
    loop_en = 1'b1;
    exp_q.delete();
    mdl(0, 0, 0);
    m_scale[0] = 40;
    m_dur[0] = 1;
    mdl(0, 0, 0);
    kick();
    foreach (exp_q[i]) begin
      wr_en = (i == 2);
      wr_addr = '0;
      wr_scale = 6'd40;
      wr_dur = 8'd1;
      @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL live_write cyc %0d got %h exp %h",
                 i, obs, exp_q[i]);
      end
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    loop_en = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== pk(40, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL stop_in_load got %h exp %h",
               obs, pk(40, 0, 0, 0, 0));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_last_change();
    int chg;
    for (int i = 0; i < DEPTH; i++) wr(i, i + 3, 1);
    last_idx = 3;
    exp_q.delete();
    mdl(0, 2, 0);
    chg = exp_q.size() - 2;
    mdl(3, 1, 1);
    kick();
    foreach (exp_q[i]) begin
      if (i == chg) last_idx = 1;
      @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL last_change cyc %0d got %h exp %h",
                 i, obs, exp_q[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    int s;
    int lst;
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < DEPTH; a++) begin
        s = ($urandom_range(0, 3) == 0) ? 0 :
            int'($urandom_range(1, 63));
        wr(a, s, int'($urandom_range(0, 2)));
      end
      lst = int'($urandom_range(0, DEPTH - 1));
      last_idx = 3'(lst);
      exp_q.delete();
      mdl(0, lst, 1);
      kick();
      foreach (exp_q[i]) begin
        @(negedge clk);
        checks++;
        if (obs !== exp_q[i]) begin
          errors++;
          $display("FAIL random r%0d cyc %0d got %h exp %h",
                   r, i, obs, exp_q[i]);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rest_skip();
    test_loop_stop();
    test_priority();
    test_live_write();
    test_last_change();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sine_tone_sequencer.md
Name: sine_tone_sequencer

Overview:
Sequencer that drives the Scale and enable inputs of the sinewave generator so it plays a programmed list of tones. It holds a small table of {scale, duration} entries written by the control logic. On start it steps through entries 0..last_idx, with an optional silent gap after each entry, and optionally loops. It sits between switch/CPU control and the generator; its Scale_Out and Enable_Out connect directly to the generator's Scale and Enable_SW_0.

Parameters:
DEPTH, 16, number of table entries (power of 2; index width IW = log2(DEPTH)).
TICK_DIV, 1024, sysclk cycles per duration tick (>=2).
GAP_TICKS, 1, silent ticks inserted after each entry (0 = no gap).

Ports:
sysclk  input  1  system clock; all logic on rising edge.
reset  input  1  asynchronous, active-high reset.
wr_en  input  1  table write strobe.
wr_addr  input  IW  entry index to write.
wr_scale  input  6  scale value for entry (0 = rest).
wr_dur  input  8  duration in ticks (0 = skip entry).
start  input  1  begin playback at entry 0; ignored while busy.
stop  input  1  abort playback; has priority over start.
loop_en  input  1  restart at entry 0 after last_idx instead of finishing.
last_idx  input  IW  index of final entry played.
Scale_Out  output  6  registered scale to generator.
Enable_Out  output  1  registered enable to generator.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse on normal completion.
cur_idx  output  IW  entry currently loaded or playing.

Behaviour:
- Reset values: Scale_Out=1, Enable_Out=0, busy=0, done=0, cur_idx=0, state=IDLE, prescaler=0, table contents cleared to {0,0}.
- Table: synchronous write on wr_en, accepted in any state. An entry is read only in LOAD, so writing the entry currently playing affects only its next LOAD.
- States: IDLE, LOAD, PLAY, GAP.
- IDLE: Enable_Out=0, Scale_Out holds. start&!stop -> LOAD with cur_idx=0.
- LOAD (exactly 1 cycle): latch entry[cur_idx]; dur_left=dur.
  - dur==0 -> ADVANCE.
  - Otherwise -> PLAY, with prescaler=0.
  - If scale!=0, Scale_Out<=scale. If scale==0 (rest), Scale_Out holds; the generator never sees Scale=0.
- PLAY: Enable_Out=1 if the latched scale!=0, else 0. prescaler counts 0..TICK_DIV-1 and wraps.
  - Each wrap is a tick; dur_left decrements on each tick.
  - On the tick where dur_left==1: -> GAP (prescaler=0) if GAP_TICKS>0, else ADVANCE.
  - PLAY therefore lasts exactly dur*TICK_DIV cycles.
- GAP: Enable_Out=0 for GAP_TICKS*TICK_DIV cycles, then ADVANCE.
- ADVANCE (a transition, not a state):
  - cur_idx!=last_idx -> cur_idx+1, LOAD.
  - cur_idx==last_idx and loop_en=1 -> cur_idx=0, LOAD.
  - Otherwise -> IDLE; done=1 in the first IDLE cycle.
  - loop_en is sampled at that edge.
- Enable_Out is registered. It follows the state of the current cycle, so it rises on the first PLAY cycle and falls on the first GAP/IDLE cycle.
- stop in any busy state: -> IDLE next edge; Enable_Out=0 that edge; no done pulse; cur_idx holds. stop and start together in IDLE: stay IDLE.
- last_idx changed mid-play takes effect at the next ADVANCE. If cur_idx>last_idx, playback continues through DEPTH-1, wraps to 0, and stops at last_idx.
- Asynchronous reset at any time forces all reset values immediately, independent of sysclk.

Test Plan:
All cases use TICK_DIV=4 and GAP_TICKS=1.
1. Reset: assert reset mid-PLAY with no clock edge -> Enable_Out=0, Scale_Out=1, busy=0, cur_idx=0 immediately.
2. Basic sequence: entries 0={10,2}, 1={20,1}; last_idx=1; pulse start at t0.
   - LOAD t1; Enable_Out=1 with Scale_Out=10 for t2..t9; gap t10..t13.
   - LOAD t14; Scale_Out=20 with Enable_Out=1 for t15..t18; gap t19..t22.
   - done=1 and busy=0 at t23.
3. Rest/skip: entries 0={12,1}, 1={0,2}, 2={33,0}, 3={7,1}; last_idx=3.
   - Enable_Out low for all 8 cycles of entry 1, with Scale_Out held at 12.
   - Entry 2 occupies a single LOAD cycle, with no Enable_Out and no Scale_Out change.
   - Then Scale_Out=7.
4. Loop and stop: loop_en=1, last_idx=0, entry 0={5,1}.
   - Entry 0 repeats every 9 cycles with no done pulse.
   - stop in the 2nd PLAY cycle -> next edge Enable_Out=0, busy=0, done never asserted.
5. Priority and ignore: start&stop together in IDLE -> stays IDLE. A start pulse during PLAY does not change cur_idx or timing.
6. Live write: during PLAY of entry 0={10,1} with loop_en=1, write entry 0={40,1} -> current playback stays Scale_Out=10; the next LOAD gives Scale_Out=40.
